mmio_seg_display: RTL and testbench
===================================

# mmio_seg_display

Memory-mapped, N-digit multiplexed seven-segment display controller that sits on the data-memory bus beside `DataMemory`. It lets software running on the `arm` core drive the board display with ordinary store instructions. It holds a double-buffered hex value plus control masks, scans digits from a programmable refresh divider, and swaps the buffered value in only at frame boundaries so the display never shows a torn value.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: number of scanned digits, range 1..8.
- `REFRESH_DIV`, default 50000: clk cycles per digit slot, minimum 2.
- `BASE_ADDR`, default 32'hFFFF_0000: word-aligned base address of the register block.
- `ACTIVE_LOW_OUT`, default 1: when 1, `seg`, `dp` and `an` are driven active-low (common-anode boards).

Ports:
- `clk`, input, 1: single system clock.
- `reset`, input, 1: asynchronous, active-low (0 = reset). Assertion is asynchronous; deassertion is sampled on `clk`.
- `we`, input, 1: bus write strobe, same cycle as `address`/`write_data`.
- `address`, input, 32: bus byte address.
- `write_data`, input, 32: bus write data.
- `read_data`, output, 32: combinational readback of the addressed register. It is 0 when the address misses the block.
- `hit`, output, 1: combinational; 1 when `address` falls in [BASE_ADDR, BASE_ADDR+11].
- `seg`, output, 7: segments a..g, with bit 0 = a.
- `dp`, output, 1: decimal point.
- `an`, output, NUM_DIGITS: digit enables, with bit 0 = rightmost digit.

## Operation
Registers are selected by address[3:2]. Offset 12 is unmapped: writes are ignored and reads return 0.
- **VALUE, +0x0, R/W:** writes go to PENDING[4*NUM_DIGITS-1:0] and upper bits are dropped. Reads return PENDING.
- **CTRL, +0x4, R/W:**
  - [0] enable
  - [15:8] dp mask
  - [23:16] blank mask, which forces the corresponding digit dark
  - other bits read 0
- **STATUS, +0x8, RO:**
  - [15:0] frame counter, which wraps at 16'hFFFF → 0
  - [18:16] current digit index
  - [24] swap pending flag

Writes to STATUS are ignored.

Double buffering:
- A VALUE write sets `swap_pending`.
- At a frame boundary (the refresh tick that wraps the digit index from NUM_DIGITS-1 to 0), ACTIVE ← PENDING, `swap_pending` clears, and the frame counter increments.
- When enable = 0, ACTIVE tracks PENDING on every cycle and `swap_pending` stays 0.
- If a VALUE write coincides with a frame-boundary tick, the new data is the data swapped in and `swap_pending` ends 0.

Scan:
- The refresh counter counts 0..REFRESH_DIV-1. `tick` = 1 when the counter equals REFRESH_DIV-1, and the counter then wraps to 0.
- On `tick`, the digit index advances mod NUM_DIGITS.
- The counter and index run only while enable = 1. Clearing enable holds both at their current values.

Output selection for digit i = index:
- The nibble is ACTIVE[4i+3:4i], decoded as hex 0-F.
- `an` one-hot selects i.
- `dp` = CTRL.dp[i].
- If enable = 0 or CTRL.blank[i] = 1, all of `an`, `seg` and `dp` are inactive.
- Polarity is applied last, per ACTIVE_LOW_OUT.

## Timing
- Reset values:
  - PENDING = ACTIVE = 0
  - CTRL = 0
  - frame counter, refresh counter, index and `swap_pending` = 0
  - `an`, `seg`, `dp` inactive (all ones when ACTIVE_LOW_OUT = 1)
- Register writes take effect at the rising edge where `we` and `hit` are both 1. Readback shows the new value the next cycle.
- `seg`/`an`/`dp` are registered: they update 1 cycle after the index or ACTIVE changes.
- Each digit is lit for exactly REFRESH_DIV cycles. One frame is NUM_DIGITS × REFRESH_DIV cycles.
- Reset asserted mid-scan or mid-swap clears all state immediately, including any discarded pending value. Scanning restarts from digit 0.

## Structure
- Package `seg_display_pkg`:
  - register offset constants (VALUE = 0, CTRL = 4, STATUS = 8)
  - CTRL field bit positions
  - 16-entry hex segment table, active-high
- Sub-module `hex7seg`: purely combinational 4-bit nibble → 7-bit active-high segments. It is used once, on the selected nibble.
- Top-level integration: `top` routes `hit` to mux `read_data` ahead of `DataMemory` and gates `DataMemory` `we` with !hit.

## Test plan
- Reset with `reset` = 0 mid-run → `an` = 4'hF, `seg` = 7'h7F, `dp` = 1, and all registers read 0.
- REFRESH_DIV = 4, CTRL = 1, VALUE = 32'h0000_1234 → after the swap, `an` cycles 1110 → 1101 → 1011 → 0111 with 4 cycles each, and `seg` shows 4, 3, 2, 1 (digit 0 = 4).
- While enabled mid-frame, write VALUE = 0xABCD → STATUS[24] = 1 and the old digits persist until index wraps to 0. Then the new digits appear, STATUS[24] = 0, and the frame counter increments by 1.
- CTRL = 32'h0002_0501 → digit 1 is dark, and `dp` is active on digits 0 and 2 only.
- Clear enable while index = 2 → outputs go inactive and STATUS[18:16] holds 2. Re-enable → the scan resumes at digit 2.
- Write to address BASE+12, and read it → no state change and read 0. An access outside the block → `hit` = 0 and `read_data` = 0.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared constants for the memory-mapped seven-segment display controller.
package seg_display_pkg;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned REG_SPAN = 12;   // three 32-bit registers

   // Register byte offsets within the block
   localparam logic [3:0] OFF_VALUE  = 4'h0;
   localparam logic [3:0] OFF_CTRL   = 4'h4;
   localparam logic [3:0] OFF_STATUS = 4'h8;

   // CTRL field positions
   localparam int unsigned CTRL_EN_BIT    = 0;
   localparam int unsigned CTRL_DP_LSB    = 8;
   localparam int unsigned CTRL_BLANK_LSB = 16;
   localparam int unsigned MASK_W         = 8;

   // STATUS field positions
   localparam int unsigned STATUS_IDX_LSB  = 16;
   localparam int unsigned STATUS_SWAP_BIT = 24;

   // Hex glyphs, active-high, bit 0 = segment a; entry 0 is the rightmost
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-high seven-segment decoder.
module hex7seg
   import seg_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_c
);

   // Table lookup of the hex glyph
   always_comb begin
      seg_c = HEX_SEG[nibble];
   end

endmodule

// File: rtl/mmio_seg_display.sv
// Memory-mapped, double-buffered, multiplexed N-digit seven-segment controller.
module mmio_seg_display
   import seg_display_pkg::*;
#(
   parameter int unsigned  NUM_DIGITS     = 4,
   parameter int unsigned  REFRESH_DIV    = 50000,
   parameter logic [31:0]  BASE_ADDR      = 32'hFFFF_0000,
   parameter bit           ACTIVE_LOW_OUT = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W-1:0]     write_data,
   output logic [DATA_W-1:0]     read_data,
   output logic                  hit,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] an
);

   localparam int unsigned VAL_W = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W = 3;

   logic [ADDR_W-1:0]     off;
   logic [3:0]            reg_off;
   logic                  wr_value;
   logic                  wr_ctrl;
   logic                  tick;
   logic                  frame_tick;
   logic [VAL_W-1:0]      pending;
   logic [VAL_W-1:0]      pending_nxt;
   logic [VAL_W-1:0]      active;
   logic [VAL_W-1:0]      active_shift;
   logic                  en;
   logic [MASK_W-1:0]     dp_mask;
   logic [MASK_W-1:0]     blank_mask;
   logic [15:0]           frame_cnt;
   logic [CNT_W-1:0]      rcnt;
   logic [IDX_W-1:0]      idx;
   logic                  swap_pending;
   logic                  lit;
   logic [3:0]            nibble;
   logic [6:0]            glyph;
   logic                  unused_wdata;

   // Address decode relative to the block base
   assign off      = address - BASE_ADDR;
   assign hit      = (off < ADDR_W'(REG_SPAN));
   assign reg_off  = {off[3:2], 2'b00};
   assign wr_value = we && hit && (reg_off == OFF_VALUE);
   assign wr_ctrl  = we && hit && (reg_off == OFF_CTRL);

   assign tick         = en && (rcnt == CNT_W'(REFRESH_DIV - 1));
   assign frame_tick   = tick && (idx == IDX_W'(NUM_DIGITS - 1));
   assign pending_nxt  = wr_value ? write_data[VAL_W-1:0] : pending;
   assign unused_wdata = ^write_data;

   // Register readback; misses and the unmapped slot read as zero
   always_comb begin
      read_data = '0;
      if (hit) begin
         case (reg_off)
            OFF_VALUE:  read_data = DATA_W'(pending);
            OFF_CTRL:   read_data = {8'b0, blank_mask, dp_mask, 7'b0, en};
            OFF_STATUS: read_data = {7'b0, swap_pending, 5'b0, idx, frame_cnt};
            default:    read_data = '0;
         endcase
      end
   end

   // Software-visible registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending    <= '0;
         en         <= 1'b0;
         dp_mask    <= '0;
         blank_mask <= '0;
      end else begin
         pending <= pending_nxt;
         if (wr_ctrl) begin
            en         <= write_data[CTRL_EN_BIT];
            dp_mask    <= write_data[CTRL_DP_LSB +: MASK_W];
            blank_mask <= write_data[CTRL_BLANK_LSB +: MASK_W];
         end
      end
   end

   // Double buffer: swap at frame boundaries, follow directly while idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active       <= '0;
         swap_pending <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         if (!en) begin
            active       <= pending_nxt;
            swap_pending <= 1'b0;
         end else if (frame_tick) begin
            active       <= pending_nxt;
            swap_pending <= 1'b0;
            frame_cnt    <= frame_cnt + 16'd1;
         end else if (wr_value) begin
            swap_pending <= 1'b1;
         end
      end
   end

   // Refresh divider and digit scan; both freeze while disabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rcnt <= '0;
         idx  <= '0;
      end else if (en) begin
         if (tick) begin
            rcnt <= '0;
            idx  <= frame_tick ? '0 : idx + IDX_W'(1);
         end else begin
            rcnt <= rcnt + CNT_W'(1);
         end
      end
   end

   // Select the current digit's nibble
   always_comb begin
      active_shift = active >> {idx, 2'b00};
      nibble       = active_shift[3:0];
      lit          = en && !blank_mask[idx];
   end

   hex7seg u_hex7seg (
      .nibble (nibble),
      .seg_c  (glyph)
   );

   // Registered drive with polarity applied last
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg <= {7{ACTIVE_LOW_OUT}};
         dp  <= ACTIVE_LOW_OUT;
         an  <= {NUM_DIGITS{ACTIVE_LOW_OUT}};
      end else begin
         seg <= (lit ? glyph : 7'd0) ^ {7{ACTIVE_LOW_OUT}};
         dp  <= (lit && dp_mask[idx]) ^ ACTIVE_LOW_OUT;
         an  <= (lit ? (NUM_DIGITS'(1) << idx) : NUM_DIGITS'(0))
                ^ {NUM_DIGITS{ACTIVE_LOW_OUT}};
      end
   end

endmodule

// File: tb/tb_mmio_seg_display.sv
// Bench for mmio_seg_display: frame-position model plus directed literal checks.
module tb_mmio_seg_display;

   localparam int unsigned ND    = 4;
   localparam int unsigned DIV   = 4;
   localparam int unsigned FRAME = ND * DIV;
   localparam logic [31:0] BASE  = 32'hFFFF_0000;
   localparam logic [31:0] IDLE  = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        we = 1'b0;
   logic [31:0] address = IDLE;
   logic [31:0] write_data = 32'd0;
   logic [31:0] read_data;
   logic        hit;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;

   int total = 0;
   int bad   = 0;

   mmio_seg_display #(
      .NUM_DIGITS     (ND),
      .REFRESH_DIV    (DIV),
      .BASE_ADDR      (BASE),
      .ACTIVE_LOW_OUT (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .we         (we),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .hit        (hit),
      .seg        (seg),
      .dp         (dp),
      .an         (an)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Seven-segment glyphs, segment a in bit 0, lit = 1
   function automatic logic [6:0] glyph(input logic [3:0] h);
      case (h)
         4'h0: glyph = 7'b0111111;  4'h1: glyph = 7'b0000110;
         4'h2: glyph = 7'b1011011;  4'h3: glyph = 7'b1001111;
         4'h4: glyph = 7'b1100110;  4'h5: glyph = 7'b1101101;
         4'h6: glyph = 7'b1111101;  4'h7: glyph = 7'b0000111;
         4'h8: glyph = 7'b1111111;  4'h9: glyph = 7'b1101111;
         4'hA: glyph = 7'b1110111;  4'hB: glyph = 7'b1111100;
         4'hC: glyph = 7'b0111001;  4'hD: glyph = 7'b1011110;
         4'hE: glyph = 7'b1111001;  default: glyph = 7'b1110001;
      endcase
   endfunction

   // Model: scan position counts enabled cycles within the current frame
   logic [15:0] m_pend = '0, m_act = '0, m_frame = '0;
   logic        m_en = 1'b0, m_swp = 1'b0;
   logic [7:0]  m_dp = '0, m_blank = '0;
   int          m_pos = 0;
   logic [3:0]  e_an = 4'hF;
   logic [6:0]  e_seg = 7'h7F;
   logic        e_dp = 1'b1;

   function automatic logic m_hit(input logic [31:0] a);
      logic [31:0] o;
      o = a - BASE;
      m_hit = (o < 32'd12);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] o;
      int          d;
      o = a - BASE;
      d = m_pos / DIV;
      m_read = 32'd0;
      if (m_hit(a)) begin
         case (o[3:2])
            2'd0:    m_read = {16'd0, m_pend};
            2'd1:    m_read = {8'd0, m_blank, m_dp, 7'd0, m_en};
            2'd2:    m_read = {7'd0, m_swp, 5'd0, 3'(d), m_frame};
            default: m_read = 32'd0;
         endcase
      end
   endfunction

   // Advance the model on every edge, then check every output
   always @(posedge clk) begin : model
      int          d;
      logic        lit, w_val, w_ctl, boundary;
      logic [31:0] o;
      logic [15:0] pn;
      if (!reset) begin
         m_pend = '0; m_act = '0; m_frame = '0; m_en = 1'b0; m_swp = 1'b0;
         m_dp = '0; m_blank = '0; m_pos = 0;
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
         d     = m_pos / DIV;
         lit   = m_en && !m_blank[d];
         e_an  = lit ? ~(4'b0001 << d) : 4'hF;
         e_seg = lit ? ~glyph(m_act[4*d +: 4]) : 7'h7F;
         e_dp  = !(lit && m_dp[d]);
         o        = address - BASE;
         w_val    = we && m_hit(address) && (o[3:2] == 2'd0);
         w_ctl    = we && m_hit(address) && (o[3:2] == 2'd1);
         boundary = m_en && (m_pos == FRAME - 1);
         pn       = w_val ? write_data[15:0] : m_pend;
         if (!m_en || boundary) begin
            m_act = pn;
            m_swp = 1'b0;
         end else if (w_val) begin
            m_swp = 1'b1;
         end
         if (boundary) m_frame = m_frame + 16'd1;
         if (m_en) m_pos = (m_pos + 1) % FRAME;
         m_pend = pn;
         if (w_ctl) begin
            m_en    = write_data[0];
            m_dp    = write_data[15:8];
            m_blank = write_data[23:16];
         end
      end
      #1;
      chk("an", an, e_an);
      chk("seg", seg, e_seg);
      chk("dp", dp, e_dp);
      chk("hit", hit, m_hit(address));
      chk("read_data", read_data, m_read(address));
   end

   // Bus write; call at a falling edge, returns at the next falling edge
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      we = 1'b1; address = a; write_data = d;
      @(negedge clk);
      we = 1'b0; address = IDLE; write_data = 32'd0;
   endtask

   task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      address = a;
      #1;
      chk(name, read_data, exp);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      @(negedge clk);
      reset = 1'b1;

      // Load 0x1234 while idle (upper bits dropped), then enable
      wr(BASE, 32'hFFFF_1234);
      rd("value_rd", BASE, 32'h0000_1234);
      wr(BASE + 4, 32'h0000_0001);
      @(posedge clk); #2;
      chk("d0_an", an, 4'b1110);  chk("d0_seg", seg, 7'h19);
      repeat (4) @(posedge clk); #2;
      chk("d1_an", an, 4'b1101);  chk("d1_seg", seg, 7'h30);
      repeat (4) @(posedge clk); #2;
      chk("d2_an", an, 4'b1011);  chk("d2_seg", seg, 7'h24);
      repeat (4) @(posedge clk); #2;
      chk("d3_an", an, 4'b0111);  chk("d3_seg", seg, 7'h79);

      // Mid-frame write: old digits persist until the wrap
      @(negedge clk);
      wr(BASE, 32'h0000_ABCD);
      rd("stat_pend", BASE + 8, 32'h0103_0000);
      @(posedge clk); #2;
      chk("old_seg", seg, 7'h79);
      @(negedge clk); #1;
      chk("stat_pend2", read_data, 32'h0103_0000);
      @(negedge clk); #1;
      chk("stat_swap", read_data, 32'h0000_0001);
      @(posedge clk); #2;
      chk("new_an", an, 4'b1110);  chk("new_seg", seg, 7'h21);

      // Blank digit 1, decimal points on digits 0 and 2
      @(negedge clk);
      wr(BASE + 4, 32'h0002_0501);
      rd("ctrl_rd", BASE + 4, 32'h0002_0501);
      @(posedge clk); #2;
      chk("m0_an", an, 4'b1110);  chk("m0_dp", dp, 1'b0);  chk("m0_seg", seg, 7'h21);
      repeat (2) @(posedge clk); #2;
      chk("m1_an", an, 4'hF);  chk("m1_seg", seg, 7'h7F);  chk("m1_dp", dp, 1'b1);
      repeat (4) @(posedge clk); #2;
      chk("m2_an", an, 4'b1011);  chk("m2_dp", dp, 1'b0);  chk("m2_seg", seg, 7'h03);

      // Disable on digit 2: outputs dark, index held
      @(negedge clk);
      wr(BASE + 4, 32'h0002_0500);
      rd("hold_stat", BASE + 8, 32'h0002_0001);
      @(posedge clk); #2;
      chk("off_an", an, 4'hF);  chk("off_seg", seg, 7'h7F);  chk("off_dp", dp, 1'b1);
      repeat (6) @(negedge clk);
      #1;
      chk("hold_stat2", read_data, 32'h0002_0001);
      @(negedge clk);
      wr(BASE, 32'h0000_5678);
      rd("idle_swap", BASE + 8, 32'h0002_0001);
      wr(BASE + 4, 32'h0000_0001);
      @(posedge clk); #2;
      chk("resume_an", an, 4'b1011);  chk("resume_seg", seg, 7'h02);

      // Back-to-back VALUE writes across a frame boundary
      @(negedge clk);
      for (int k = 0; k < 20; k++) wr(BASE, 32'(k) * 32'h1111);
      repeat (20) @(negedge clk);
      rd("burst_val", BASE, 32'h0000_4443);

      // Unmapped slot and out-of-block accesses
      wr(BASE + 12, 32'hDEAD_BEEF);
      rd("unmapped_rd", BASE + 12, 32'd0);
      chk("unmapped_hit", hit, 1'b0);
      address = BASE + 11; #1;
      chk("edge_hit", hit, 1'b1);
      rd("below_rd", BASE - 4, 32'd0);
      chk("below_hit", hit, 1'b0);
      rd("far_rd", IDLE, 32'd0);
      chk("far_hit", hit, 1'b0);
      rd("val_kept", BASE, 32'h0000_4443);
      rd("ctrl_kept", BASE + 4, 32'h0000_0001);

      // Reset in the middle of a pending swap
      @(negedge clk);
      wr(BASE, 32'h0000_9999);
      reset = 1'b0;
      #1;
      chk("mrst_an", an, 4'hF);  chk("mrst_seg", seg, 7'h7F);  chk("mrst_dp", dp, 1'b1);
      rd("mrst_val", BASE, 32'd0);
      rd("mrst_ctrl", BASE + 4, 32'd0);
      rd("mrst_stat", BASE + 8, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      wr(BASE + 4, 32'h0000_0001);
      @(posedge clk); #2;
      chk("restart_an", an, 4'b1110);  chk("restart_seg", seg, 7'h40);

      repeat (20) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
